rst_seq: RTL and testbench
==========================

Name: rst_seq

Overview:
- Reset sequencer placed directly downstream of the board PLL wrapper.
- Runs on the PLL output clock and consumes the PLL's asynchronous lock indicator.
- Produces the core/system reset: held until lock has been stable for a qualification window, then stretched for a further hold window before release.
- Re-asserts reset on lock loss; counts lock-loss events for debug.

Parameters:
- LOCK_CYCLES, 1024, consecutive synchronized-lock cycles required before the hold phase (min 1)
- HOLD_CYCLES, 16, cycles reset stays asserted after lock qualification (min 1)
- WDT_CYCLES, 65536, watchdog timeout in cycles (used only with RSTSEQ_WDT_EN; min 2)

Ports:
- CLK  in  1  PLL output clock; the only clock
- RES  in  1  asynchronous active-high reset (board reset button); clears all state
- LOCKED  in  1  PLL lock, asynchronous to CLK
- KICK  in  1  watchdog service strobe from the core, sampled on CLK
- RES_OUT  out  1  active-high system reset, registered
- READY  out  1  high while in RUN, registered
- STATE  out  2  FSM state: 0 WAIT, 1 STABLE, 2 HOLD, 3 RUN
- LOSS_CNT  out  8  saturating count of lock losses observed in RUN
- WDT_TRIP  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- Reset (RES=1, asynchronous assert):
  - sync flops = 0, STATE = WAIT, cnt = 0
  - RES_OUT = 1, READY = 0, LOSS_CNT = 0, WDT_TRIP = 0
- Reset release is not re-synchronized; the FSM holds RES_OUT high through WAIT anyway.
- LOCKED passes a 2-flop synchronizer → lock_s. All decisions use lock_s only.
- Counter cnt: width clog2(max(LOCK_CYCLES, HOLD_CYCLES, WDT_CYCLES)); cleared on every state change.
- FSM transitions, evaluated per rising edge:
  - WAIT: lock_s=1 → STABLE.
  - STABLE: lock_s=0 → WAIT; else if cnt==LOCK_CYCLES-1 → HOLD; else cnt+1.
  - HOLD: lock_s=0 → WAIT; else if cnt==HOLD_CYCLES-1 → RUN; else cnt+1.
  - RUN: lock_s=0 → WAIT, and LOSS_CNT+1, saturating at 255.
- Outputs are registered from the next state:
  - RES_OUT = (next != RUN); READY = (next == RUN).
  - Both change on the same edge STATE changes. No glitches.
- Release latency: with the first edge sampling LOCKED=1 counted as edge 1, RES_OUT falls at edge 3+LOCK_CYCLES+HOLD_CYCLES, provided LOCKED stays high.
- Assert latency: LOCKED low sampled at edge j (in RUN) → STATE=WAIT and RES_OUT=1 after edge j+2.
- Lock dropout during STABLE or HOLD restarts qualification from WAIT. LOSS_CNT is unchanged (counts RUN losses only).
- A lock pulse shorter than 1 CLK may be missed by the synchronizer; this is acceptable.
- RES mid-sequence: immediate return to reset values, including LOSS_CNT.

Optional Feature:
- RSTSEQ_WDT_EN defined:
  - In RUN, cnt increments each cycle; KICK=1 clears it to 0.
  - If cnt==WDT_CYCLES-1 with KICK=0: WDT_TRIP=1 for one cycle, transition to HOLD, RES_OUT=1 next edge. The sequence then re-releases after HOLD_CYCLES without lock re-qualification.
  - Lock loss in the same cycle as expiry: lock loss wins (→ WAIT, LOSS_CNT+1, WDT_TRIP stays 0).
  - KICK outside RUN is ignored.
- RSTSEQ_WDT_EN undefined:
  - KICK is ignored; WDT_TRIP is tied 0.
  - cnt is not advanced in RUN; RUN persists until lock loss or RES.

Test Plan:
- LOCK_CYCLES=4, HOLD_CYCLES=8; RES pulse, then LOCKED=1 sampled at edge 1 → RES_OUT falls and READY rises at edge 15; STATE sequence 0,1,2,3.
- LOCKED held 0 for 1000 cycles after RES → RES_OUT=1, STATE=0 throughout, LOSS_CNT=0.
- LOCKED drops for 3 cycles during HOLD → STATE returns to 0; after relock, full 3+4+8 edge latency again; LOSS_CNT=0.
- In RUN, toggle LOCKED low/high 260 times → RES_OUT reasserts 2 edges after each low sample; LOSS_CNT saturates at 255.
- RSTSEQ_WDT_EN, WDT_CYCLES=32: KICK every 20 cycles → no WDT_TRIP; stop KICK → WDT_TRIP pulse 1 cycle, RES_OUT high for 8 cycles, then low; LOCKED 0 on expiry cycle → WDT_TRIP=0, STATE=0.
- Assert RES while in HOLD and in RUN → outputs return to reset values asynchronously (RES_OUT=1 before next edge), LOSS_CNT=0.

Source files
------------

// File: rtl/rst_seq.sv
// ============================================================================
// Module      : rst_seq
// Description : PLL-downstream reset sequencer. Synchronizes LOCKED, qualifies
//               it for LOCK_CYCLES, holds reset for HOLD_CYCLES, then releases.
//               Optional watchdog enabled by defining RSTSEQ_WDT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rst_seq #(
    parameter int LOCK_CYCLES = 1024,
    parameter int HOLD_CYCLES = 16,
    parameter int WDT_CYCLES  = 65536
) (
    input  logic       CLK,
    input  logic       RES,
    input  logic       LOCKED,
    input  logic       KICK,
    output logic       RES_OUT,
    output logic       READY,
    output logic [1:0] STATE,
    output logic [7:0] LOSS_CNT,
    output logic       WDT_TRIP
);

    localparam int c_MAX_LH = (LOCK_CYCLES > HOLD_CYCLES) ? LOCK_CYCLES : HOLD_CYCLES;
    localparam int c_MAX    = (c_MAX_LH > WDT_CYCLES) ? c_MAX_LH : WDT_CYCLES;
    localparam int c_CW     = (c_MAX > 1) ? $clog2(c_MAX) : 1;

    localparam logic [c_CW-1:0] c_LOCK_LAST = c_CW'(LOCK_CYCLES - 1);
    localparam logic [c_CW-1:0] c_HOLD_LAST = c_CW'(HOLD_CYCLES - 1);
`ifdef RSTSEQ_WDT_EN
    localparam logic [c_CW-1:0] c_WDT_LAST  = c_CW'(WDT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_STABLE = 2'd1,
        S_HOLD   = 2'd2,
        S_RUN    = 2'd3
    } state_t;

    logic            r_sync1;
    logic            r_sync2;
    state_t          r_state;
    logic [c_CW-1:0] r_cnt;
    logic            r_res_out;
    logic            r_ready;
    logic [7:0]      r_loss_cnt;
    logic            r_wdt_trip;

    state_t          w_next;
    logic [c_CW-1:0] w_cnt_next;
    logic            w_loss_inc;
    logic            w_trip;
    logic            w_lock_s;

    assign w_lock_s = r_sync2;

`ifndef RSTSEQ_WDT_EN
    // KICK has no function without the watchdog.
    logic w_unused_kick;
    assign w_unused_kick = KICK;
`endif

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_loss_inc = 1'b0;
        w_trip     = 1'b0;
        case (r_state)
            S_WAIT: begin
                if (w_lock_s) w_next = S_STABLE;
            end
            S_STABLE: begin
                if (!w_lock_s)                w_next = S_WAIT;
                else if (r_cnt == c_LOCK_LAST) w_next = S_HOLD;
                else                           w_cnt_next = r_cnt + 1'b1;
            end
            S_HOLD: begin
                if (!w_lock_s)                w_next = S_WAIT;
                else if (r_cnt == c_HOLD_LAST) w_next = S_RUN;
                else                           w_cnt_next = r_cnt + 1'b1;
            end
            S_RUN: begin
                // Lock loss takes priority over a coincident watchdog expiry.
                if (!w_lock_s) begin
                    w_next     = S_WAIT;
                    w_loss_inc = 1'b1;
                end
`ifdef RSTSEQ_WDT_EN
                else if (KICK) begin
                    w_cnt_next = '0;
                end else if (r_cnt == c_WDT_LAST) begin
                    w_next = S_HOLD;
                    w_trip = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
`endif
            end
            default: w_next = S_WAIT;
        endcase
        if (w_next != r_state) w_cnt_next = '0;
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_state    <= S_WAIT;
            r_cnt      <= '0;
            r_res_out  <= 1'b1;
            r_ready    <= 1'b0;
            r_loss_cnt <= 8'd0;
            r_wdt_trip <= 1'b0;
        end else begin
            r_sync1    <= LOCKED;
            r_sync2    <= r_sync1;
            r_state    <= w_next;
            r_cnt      <= w_cnt_next;
            r_res_out  <= (w_next != S_RUN);
            r_ready    <= (w_next == S_RUN);
            r_wdt_trip <= w_trip;
            if (w_loss_inc && (r_loss_cnt != 8'hFF)) r_loss_cnt <= r_loss_cnt + 8'd1;
        end
    end

    assign RES_OUT  = r_res_out;
    assign READY    = r_ready;
    assign STATE    = r_state;
    assign LOSS_CNT = r_loss_cnt;
    assign WDT_TRIP = r_wdt_trip;

endmodule

`default_nettype wire

// File: tb/tb_rst_seq.sv
// ============================================================================
// Module      : tb_rst_seq
// Description : Directed self-checking bench for rst_seq (LOCK=4, HOLD=8,
//               WDT=32); watchdog scenarios run when RSTSEQ_WDT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rst_seq;

    localparam int LOCK_CYCLES = 4;
    localparam int HOLD_CYCLES = 8;
    localparam int WDT_CYCLES  = 32;
    localparam int REL_EDGE    = 3 + LOCK_CYCLES + HOLD_CYCLES;  // 15

    logic       CLK;
    logic       RES;
    logic       LOCKED;
    logic       KICK;
    logic       RES_OUT;
    logic       READY;
    logic [1:0] STATE;
    logic [7:0] LOSS_CNT;
    logic       WDT_TRIP;

    int checks = 0;
    int errors = 0;

    rst_seq #(
        .LOCK_CYCLES(LOCK_CYCLES),
        .HOLD_CYCLES(HOLD_CYCLES),
        .WDT_CYCLES (WDT_CYCLES)
    ) dut (
        .CLK     (CLK),
        .RES     (RES),
        .LOCKED  (LOCKED),
        .KICK    (KICK),
        .RES_OUT (RES_OUT),
        .READY   (READY),
        .STATE   (STATE),
        .LOSS_CNT(LOSS_CNT),
        .WDT_TRIP(WDT_TRIP)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Expected state after edge e, counting the first edge that samples LOCKED=1 as 1.
    function automatic logic [1:0] exp_state(input int e);
        if (e < 3)                          return 2'd0;
        else if (e < 3 + LOCK_CYCLES)       return 2'd1;
        else if (e < REL_EDGE)              return 2'd2;
        else                                return 2'd3;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        tick();
        RES = 1'b1;
        tick();
        tick();
        RES = 1'b0;
    endtask

    // Drive LOCKED high and advance exactly to the RUN entry edge.
    task automatic lock_to_run();
        LOCKED = 1'b1;
        for (int e = 1; e <= REL_EDGE; e++) tick();
    endtask

    task automatic test_reset();
        RES = 1'b1; LOCKED = 1'b0; KICK = 1'b0;
        tick();
        checks++;
        if ({RES_OUT, READY, STATE, LOSS_CNT, WDT_TRIP} !== {1'b1, 1'b0, 2'd0, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: got res_out=%b ready=%b state=%0d loss=%0d trip=%b, want 1 0 0 0 0",
                     RES_OUT, READY, STATE, LOSS_CNT, WDT_TRIP);
        end
        RES = 1'b0;
    endtask

    task automatic test_release();
        logic [1:0] es;
        apply_reset();
        LOCKED = 1'b1;
        for (int e = 1; e <= REL_EDGE; e++) begin
            tick();
            es = exp_state(e);
            checks++;
            if ({STATE, RES_OUT, READY} !== {es, es != 2'd3, es == 2'd3}) begin
                errors++;
                $display("FAIL release_edge%0d: got state=%0d res_out=%b ready=%b, want state=%0d res_out=%b ready=%b",
                         e, STATE, RES_OUT, READY, es, es != 2'd3, es == 2'd3);
            end
        end
        checks++;
        if (LOSS_CNT !== 8'd0) begin
            errors++;
            $display("FAIL release_loss: got %0d want 0", LOSS_CNT);
        end
    endtask

    task automatic test_no_lock();
        int bad = 0;
        apply_reset();
        LOCKED = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            checks++;
            if ({RES_OUT, READY, STATE, LOSS_CNT} !== {1'b1, 1'b0, 2'd0, 8'd0}) begin
                errors++;
                if (bad < 5)
                    $display("FAIL no_lock_cycle%0d: got res_out=%b ready=%b state=%0d loss=%0d, want 1 0 0 0",
                             i, RES_OUT, READY, STATE, LOSS_CNT);
                bad++;
            end
        end
    endtask

    task automatic test_hold_dropout();
        logic [1:0] es;
        apply_reset();
        LOCKED = 1'b1;
        for (int e = 1; e <= 10; e++) tick();
        checks++;
        if (STATE !== 2'd2) begin
            errors++;
            $display("FAIL dropout_in_hold: got state=%0d want 2", STATE);
        end
        // Low sampled at edges 11..13; FSM sees it at edge 13.
        LOCKED = 1'b0;
        tick(); tick(); tick();
        checks++;
        if ({STATE, RES_OUT} !== {2'd0, 1'b1}) begin
            errors++;
            $display("FAIL dropout_to_wait: got state=%0d res_out=%b want 0 1", STATE, RES_OUT);
        end
        LOCKED = 1'b1;
        for (int e = 1; e <= REL_EDGE; e++) begin
            tick();
            es = exp_state(e);
            checks++;
            if ({STATE, RES_OUT, READY} !== {es, es != 2'd3, es == 2'd3}) begin
                errors++;
                $display("FAIL relock_edge%0d: got state=%0d res_out=%b ready=%b, want state=%0d",
                         e, STATE, RES_OUT, READY, es);
            end
        end
        checks++;
        if (LOSS_CNT !== 8'd0) begin
            errors++;
            $display("FAIL dropout_loss: got %0d want 0", LOSS_CNT);
        end
    endtask

    task automatic test_run_toggle();
        int exp_loss;
        apply_reset();
        lock_to_run();
        for (int k = 1; k <= 260; k++) begin
            exp_loss = (k > 255) ? 255 : k;
            LOCKED = 1'b0;
            tick();                      // edge j samples low
            tick();                      // edge j+1: still RUN
            checks++;
            if ({STATE, RES_OUT} !== {2'd3, 1'b0}) begin
                errors++;
                $display("FAIL toggle%0d_j1: got state=%0d res_out=%b want 3 0", k, STATE, RES_OUT);
            end
            tick();                      // edge j+2: back to WAIT
            checks++;
            if ({STATE, RES_OUT, READY, LOSS_CNT} !== {2'd0, 1'b1, 1'b0, 8'(exp_loss)}) begin
                errors++;
                $display("FAIL toggle%0d_j2: got state=%0d res_out=%b ready=%b loss=%0d want 0 1 0 %0d",
                         k, STATE, RES_OUT, READY, LOSS_CNT, exp_loss);
            end
            lock_to_run();
            checks++;
            if ({STATE, READY} !== {2'd3, 1'b1}) begin
                errors++;
                $display("FAIL toggle%0d_relock: got state=%0d ready=%b want 3 1", k, STATE, READY);
            end
        end
    endtask

    task automatic test_async_reset();
        // HOLD case
        apply_reset();
        LOCKED = 1'b1;
        for (int e = 1; e <= 10; e++) tick();
        RES = 1'b1;
        #2;
        checks++;
        if ({RES_OUT, READY, STATE, LOSS_CNT} !== {1'b1, 1'b0, 2'd0, 8'd0}) begin
            errors++;
            $display("FAIL async_hold: got res_out=%b ready=%b state=%0d loss=%0d want 1 0 0 0",
                     RES_OUT, READY, STATE, LOSS_CNT);
        end
        // RUN case, with a non-zero loss count to clear
        tick();
        RES = 1'b0;
        lock_to_run();
        LOCKED = 1'b0;
        tick(); tick(); tick();
        lock_to_run();
        checks++;
        if ({STATE, LOSS_CNT} !== {2'd3, 8'd1}) begin
            errors++;
            $display("FAIL async_pre_run: got state=%0d loss=%0d want 3 1", STATE, LOSS_CNT);
        end
        RES = 1'b1;
        #2;
        checks++;
        if ({RES_OUT, READY, STATE, LOSS_CNT} !== {1'b1, 1'b0, 2'd0, 8'd0}) begin
            errors++;
            $display("FAIL async_run: got res_out=%b ready=%b state=%0d loss=%0d want 1 0 0 0",
                     RES_OUT, READY, STATE, LOSS_CNT);
        end
        tick();
        RES = 1'b0;
    endtask

`ifdef RSTSEQ_WDT_EN
    task automatic test_watchdog();
        int n;
        apply_reset();
        lock_to_run();
        for (int i = 0; i < 100; i++) begin
            KICK = (i % 20 == 0);
            tick();
            checks++;
            if ({WDT_TRIP, READY} !== {1'b0, 1'b1}) begin
                errors++;
                $display("FAIL wdt_kicked%0d: got trip=%b ready=%b want 0 1", i, WDT_TRIP, READY);
            end
        end
        KICK = 1'b0;
        // Last kick at i=80 leaves cnt=19 after i=99; expiry 13 edges later.
        n = 0;
        while (WDT_TRIP !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 13) begin
            errors++;
            $display("FAIL wdt_expiry_edge: got %0d edges want 13", n);
        end
        checks++;
        if ({STATE, RES_OUT, READY} !== {2'd2, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL wdt_trip_state: got state=%0d res_out=%b ready=%b want 2 1 0",
                     STATE, RES_OUT, READY);
        end
        for (int e = 1; e <= HOLD_CYCLES; e++) begin
            tick();
            checks++;
            if ({WDT_TRIP, RES_OUT} !== {1'b0, (e != HOLD_CYCLES)}) begin
                errors++;
                $display("FAIL wdt_hold%0d: got trip=%b res_out=%b want 0 %b",
                         e, WDT_TRIP, RES_OUT, (e != HOLD_CYCLES));
            end
        end
        // Back in RUN with cnt=0; make lock loss coincide with expiry edge 32.
        for (int e = 1; e <= 29; e++) tick();
        LOCKED = 1'b0;
        tick(); tick();
        checks++;
        if (STATE !== 2'd3) begin
            errors++;
            $display("FAIL wdt_pre_expiry: got state=%0d want 3", STATE);
        end
        tick();
        checks++;
        if ({WDT_TRIP, STATE, LOSS_CNT} !== {1'b0, 2'd0, 8'd1}) begin
            errors++;
            $display("FAIL wdt_lock_wins: got trip=%b state=%0d loss=%0d want 0 0 1",
                     WDT_TRIP, STATE, LOSS_CNT);
        end
    endtask
`else
    task automatic test_kick_ignored();
        apply_reset();
        lock_to_run();
        KICK = 1'b0;
        for (int i = 0; i < 3 * WDT_CYCLES; i++) begin
            tick();
            checks++;
            if ({WDT_TRIP, STATE, READY} !== {1'b0, 2'd3, 1'b1}) begin
                errors++;
                $display("FAIL no_wdt%0d: got trip=%b state=%0d ready=%b want 0 3 1",
                         i, WDT_TRIP, STATE, READY);
            end
        end
    endtask
`endif

    initial begin
        RES = 1'b0; LOCKED = 1'b0; KICK = 1'b0;
        test_reset();
        test_release();
        test_no_lock();
        test_hold_dropout();
        test_run_toggle();
        test_async_reset();
`ifdef RSTSEQ_WDT_EN
        test_watchdog();
`else
        test_kick_ignored();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
